// File: rtl/game_pkg.sv
// Shared encodings for the puzzle game controller: the game_status codes,
// the blank-tile mirror positions and the blank-move legality helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_CHOSE_BOARD  = 2'b00,
    ST_GAMING       = 2'b01,
    ST_GAME_INITIAL = 2'b10,
    ST_WINNED       = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    BLANK_LU = 2'b00,
    BLANK_RU = 2'b01,
    BLANK_LD = 2'b10,
    BLANK_RD = 2'b11
  } blank_pos_e;

  localparam logic [1:0] SETTLE_RELOAD = 2'd3;

  typedef struct packed {
    logic       legal;
    blank_pos_e pos;
  } blank_step_t;

  // dir is one-hot: bit0 up, bit1 right, bit2 down, bit3 left
  function automatic blank_step_t blank_step(input blank_pos_e pos, input logic [3:0] dir);
    blank_step_t r;
    r.legal = 1'b0;
    r.pos   = pos;
    case (pos)
      BLANK_LU: begin
        if (dir[1])      begin r.legal = 1'b1; r.pos = BLANK_RU; end
        else if (dir[2]) begin r.legal = 1'b1; r.pos = BLANK_LD; end
      end
      BLANK_RU: begin
        if (dir[3])      begin r.legal = 1'b1; r.pos = BLANK_LU; end
        else if (dir[2]) begin r.legal = 1'b1; r.pos = BLANK_RD; end
      end
      BLANK_LD: begin
        if (dir[0])      begin r.legal = 1'b1; r.pos = BLANK_LU; end
        else if (dir[1]) begin r.legal = 1'b1; r.pos = BLANK_RD; end
      end
      default: begin
        if (dir[0])      begin r.legal = 1'b1; r.pos = BLANK_RU; end
        else if (dir[3]) begin r.legal = 1'b1; r.pos = BLANK_LD; end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_cnt99.sv
// Two-digit BCD counter with synchronous clear, count enable and
// saturation at 99.
module bcd_cnt99 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] bcd
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = '0;
      tens_d = '0;
    end else if (en && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign bcd = {tens_q, ones_q};

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: board choice, 2-cycle init, play with blank-tile
// tracking and move/second BCD counters, and the win screen.
module game_ctrl
  import game_pkg::*;
(
  input  logic       clk_d,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       quit_btn,
  input  logic       confirm_btn,
  input  logic [3:0] act_btn,
  input  logic       tick_1hz,
  input  logic       win_flag,
  output logic [1:0] game_status,
  output logic [3:0] act,
  output logic       set,
  output logic [7:0] move_bcd,
  output logic [7:0] sec_bcd
);

  game_state_e state_q, state_d;
  blank_pos_e  blank_q, blank_d;
  logic [1:0]  settle_q, settle_d;
  logic        init_q, init_d;
  logic [3:0]  act_q, act_d;
  logic        set_q, set_d;
  // button history: {confirm, quit, start, act[3:0]}
  logic [6:0]  btn_q, btn_d;

  logic [6:0]  btn_rise;
  logic [3:0]  act_rise, act_sel;
  logic        start_rise, quit_rise, confirm_rise;
  logic        cnt_clr, move_en, sec_en;
  blank_step_t step;

  always_comb begin
    btn_d        = {confirm_btn, quit_btn, start_btn, act_btn};
    btn_rise     = btn_d & ~btn_q;
    act_rise     = btn_rise[3:0];
    start_rise   = btn_rise[4];
    quit_rise    = btn_rise[5];
    confirm_rise = btn_rise[6];
    // isolate the lowest rising direction bit
    act_sel      = act_rise & (~act_rise + 4'd1);
    step         = blank_step(blank_q, act_sel);

    state_d  = state_q;
    blank_d  = blank_q;
    settle_d = settle_q;
    init_d   = init_q;
    act_d    = '0;
    set_d    = 1'b0;
    cnt_clr  = 1'b0;
    move_en  = 1'b0;
    sec_en   = 1'b0;

    case (state_q)
      ST_CHOSE_BOARD: begin
        set_d = confirm_rise;
        if (start_rise) begin
          state_d  = ST_GAME_INITIAL;
          blank_d  = BLANK_LD;
          settle_d = SETTLE_RELOAD;
          init_d   = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      ST_GAME_INITIAL: begin
        if (init_q) init_d = 1'b0;
        else        state_d = ST_GAMING;
      end
      ST_GAMING: begin
        sec_en = tick_1hz;
        if (settle_q != 2'd0) settle_d = settle_q - 2'd1;
        if (act_sel != 4'd0) begin
          act_d = act_sel;
          if (step.legal) begin
            blank_d  = step.pos;
            settle_d = SETTLE_RELOAD;
            move_en  = 1'b1;
          end
        end
        if (quit_rise)                            state_d = ST_CHOSE_BOARD;
        else if (win_flag && settle_q == 2'd0)    state_d = ST_WINNED;
      end
      default: begin
        if (start_rise) state_d = ST_CHOSE_BOARD;
      end
    endcase
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CHOSE_BOARD;
      blank_q  <= BLANK_LD;
      settle_q <= '0;
      init_q   <= 1'b0;
      act_q    <= '0;
      set_q    <= 1'b0;
      btn_q    <= '1;
    end else begin
      state_q  <= state_d;
      blank_q  <= blank_d;
      settle_q <= settle_d;
      init_q   <= init_d;
      act_q    <= act_d;
      set_q    <= set_d;
      btn_q    <= btn_d;
    end
  end

  bcd_cnt99 u_move_cnt (
    .clk (clk_d),
    .rst (rst),
    .clr (cnt_clr),
    .en  (move_en),
    .bcd (move_bcd)
  );

  bcd_cnt99 u_sec_cnt (
    .clk (clk_d),
    .rst (rst),
    .clr (cnt_clr),
    .en  (sec_en),
    .bcd (sec_bcd)
  );

  assign game_status = state_q;
  assign act         = act_q;
  assign set         = set_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized play,
// checked every cycle against a geometric model of the blank tile and game flow.
module tb_game_ctrl;

  logic       clk_d = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0, quit_btn = 1'b0, confirm_btn = 1'b0;
  logic [3:0] act_btn = '0;
  logic       tick_1hz = 1'b0, win_flag = 1'b0;
  logic [1:0] game_status;
  logic [3:0] act;
  logic       set;
  logic [7:0] move_bcd, sec_bcd;

  int tests = 0;
  int fails = 0;

  game_ctrl dut (
    .clk_d(clk_d), .rst(rst), .start_btn(start_btn), .quit_btn(quit_btn),
    .confirm_btn(confirm_btn), .act_btn(act_btn), .tick_1hz(tick_1hz),
    .win_flag(win_flag), .game_status(game_status), .act(act), .set(set),
    .move_bcd(move_bcd), .sec_bcd(sec_bcd)
  );

  always #5 clk_d = ~clk_d;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: status uses the output codes; blank tile held as row/col (row 1 = down, col 1 = right)
  int         m_status, m_moves, m_secs, m_row, m_col, m_age, m_init_cycles;
  logic [3:0] m_act;
  logic       m_set;
  logic [6:0] m_hist;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic model_reset();
    m_status = 0; m_moves = 0; m_secs = 0; m_row = 1; m_col = 0; m_age = 3;
    m_init_cycles = 0; m_act = '0; m_set = 1'b0; m_hist = '1;
  endtask

  task automatic model_step();
    logic [6:0] b, rise;
    int  pick;
    bit  legal, quiet;
    b = {confirm_btn, quit_btn, start_btn, act_btn};
    rise = b & ~m_hist;
    m_hist = b;
    m_act = '0;
    m_set = 1'b0;
    case (m_status)
      0: begin
        m_set = rise[6];
        if (rise[4]) begin
          m_status = 2; m_moves = 0; m_secs = 0; m_row = 1; m_col = 0;
          m_age = 0; m_init_cycles = 0;
        end
      end
      2: begin
        m_init_cycles++;
        if (m_init_cycles == 2) m_status = 1;
      end
      1: begin
        quiet = (m_age >= 3);
        pick = -1;
        for (int i = 3; i >= 0; i--) if (rise[i]) pick = i;
        legal = 0;
        if (pick >= 0) begin
          m_act = 4'(1 << pick);
          case (pick)
            0: if (m_row == 1) begin m_row = 0; legal = 1; end
            2: if (m_row == 0) begin m_row = 1; legal = 1; end
            1: if (m_col == 0) begin m_col = 1; legal = 1; end
            default: if (m_col == 1) begin m_col = 0; legal = 1; end
          endcase
        end
        if (legal) begin
          m_age = 0;
          if (m_moves < 99) m_moves++;
        end else if (m_age < 3) m_age++;
        if (tick_1hz && m_secs < 99) m_secs++;
        if (rise[5]) m_status = 0;
        else if (win_flag && quiet) m_status = 3;
      end
      default: if (rise[4]) m_status = 0;
    endcase
  endtask

  always @(posedge clk_d) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("status", 8'(game_status), 8'(m_status));
    chk("act",    8'(act),         8'(m_act));
    chk("set",    8'(set),         8'(m_set));
    chk("move",   move_bcd,        to_bcd(m_moves));
    chk("sec",    sec_bcd,         to_bcd(m_secs));
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk_d);
  endtask

  task automatic press_act(input logic [3:0] v);
    act_btn = v; cyc();
    act_btn = '0; cyc();
  endtask

  task automatic enter_gaming();
    start_btn = 1'b1; cyc();
    start_btn = 1'b0; cyc(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk("rst_status", 8'(game_status), 8'h00);
    chk("rst_move", move_bcd, 8'h00);
    rst = 1'b0;
    cyc();

    // set pulse and init timing
    confirm_btn = 1'b1; cyc();
    chk("set_pulse", 8'(set), 8'h01);
    confirm_btn = 1'b0; cyc();
    chk("set_once", 8'(set), 8'h00);
    start_btn = 1'b1; cyc();
    chk("init_c1", 8'(game_status), 8'h02);
    start_btn = 1'b0; cyc();
    chk("init_c2", 8'(game_status), 8'h02);
    cyc();
    chk("gaming", 8'(game_status), 8'h01);
    win_flag = 1'b1; cyc();
    chk("win_early_ignored", 8'(game_status), 8'h01);
    win_flag = 1'b0;

    // illegal down from LD, then up/right/left walk
    act_btn = 4'b0100; cyc();
    chk("illegal_act", 8'(act), 8'h04);
    chk("illegal_move", move_bcd, 8'h00);
    act_btn = '0; cyc();
    press_act(4'b0001); chk("walk1", move_bcd, 8'h01);
    press_act(4'b0010); chk("walk2", move_bcd, 8'h02);
    press_act(4'b1000); chk("walk3", move_bcd, 8'h03);
    press_act(4'b0100); chk("walk4", move_bcd, 8'h04);

    // simultaneous rise picks lowest bit (right, legal from LD)
    act_btn = 4'b0110; cyc();
    chk("lowest_bit", 8'(act), 8'h02);
    act_btn = '0; cyc();
    chk("lowest_move", move_bcd, 8'h05);

    // saturate moves: RD <-> RU
    for (int i = 0; i < 50; i++) begin
      press_act(4'b0001);
      press_act(4'b0100);
    end
    chk("move_sat", move_bcd, 8'h99);

    // win after settling, tick in win cycle still counts
    cyc(3);
    chk("pre_win", 8'(game_status), 8'h01);
    win_flag = 1'b1; tick_1hz = 1'b1; cyc();
    chk("win", 8'(game_status), 8'h03);
    chk("win_tick", sec_bcd, 8'h01);
    win_flag = 1'b0;
    cyc(3);
    tick_1hz = 1'b0;
    chk("sec_frozen", sec_bcd, 8'h01);
    start_btn = 1'b1; cyc();
    start_btn = 1'b0;
    chk("win_exit", 8'(game_status), 8'h00);
    cyc(2);
    chk("hold_move", move_bcd, 8'h99);

    // quit beats win
    enter_gaming();
    cyc(4);
    quit_btn = 1'b1; win_flag = 1'b1; cyc();
    chk("quit_prio", 8'(game_status), 8'h00);
    quit_btn = 1'b0; win_flag = 1'b0; cyc();

    // buttons held across reset produce no pulse
    confirm_btn = 1'b1; act_btn = 4'b1111;
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc();
    chk("held_set", 8'(set), 8'h00);
    cyc();
    chk("held_set2", 8'(set), 8'h00);
    confirm_btn = 1'b0; act_btn = '0; cyc();

    // async reset mid-game
    enter_gaming();
    tick_1hz = 1'b1; cyc();
    tick_1hz = 1'b0;
    act_btn = 4'b0001; cyc();
    chk("pre_rst_act", 8'(act), 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("async_status", 8'(game_status), 8'h00);
    chk("async_act", 8'(act), 8'h00);
    chk("async_move", move_bcd, 8'h00);
    chk("async_sec", sec_bcd, 8'h00);
    cyc(2);
    act_btn = '0;
    rst = 1'b0; cyc(2);

    // randomized play
    for (int n = 0; n < 4000; n++) begin
      act_btn     = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
      start_btn   = ($urandom_range(0, 15) == 0);
      quit_btn    = ($urandom_range(0, 63) == 0);
      confirm_btn = ($urandom_range(0, 7) == 0);
      tick_1hz    = ($urandom_range(0, 3) == 0);
      win_flag    = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
